// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues reads to a 1-cycle synchronous
// instruction memory and presents {pc, inst, valid} to the IF/ID register.
// A single skid entry holds the in-flight read when downstream stalls, and a
// redirect squashes everything fetched but not yet accepted.
module if_fetch_unit #(
    parameter int                  PC_WIDTH   = 32,
    parameter int                  INST_WIDTH = 22,
    parameter int                  PC_STEP    = 1,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic                  fetch_valid,
    output logic [PC_WIDTH-1:0]   fetch_pc,
    output logic [INST_WIDTH-1:0] fetch_inst,
    output logic [31:0]           fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [PC_WIDTH-1:0]     pc_reg;
    logic                    inflight_reg;
    logic [PC_WIDTH-1:0]     inflight_pc_reg;
    logic                    skid_valid_reg;
    logic [PC_WIDTH-1:0]     skid_pc_reg;
    logic [INST_WIDTH-1:0]   skid_inst_reg;
    logic [31:0]             count_reg;

    logic                    issue;
    logic                    sel_valid;
    logic [PC_WIDTH-1:0]     sel_pc;
    logic [INST_WIDTH-1:0]   sel_inst;
    logic                    accept;
    logic                    skid_capture;

    // A new read goes out whenever we are past boot and nothing blocks it.
    assign issue     = (state_reg != ST_BOOT) && !stall && !redirect;
    assign imem_req  = issue;
    assign imem_addr = pc_reg;

    // The skid entry is older than the in-flight read, so it is presented first.
    always_comb begin
        sel_valid = 1'b0;
        sel_pc    = '0;
        sel_inst  = '0;
        if (skid_valid_reg) begin
            sel_valid = 1'b1;
            sel_pc    = skid_pc_reg;
            sel_inst  = skid_inst_reg;
        end else if (inflight_reg) begin
            sel_valid = 1'b1;
            sel_pc    = inflight_pc_reg;
            sel_inst  = imem_rdata;
        end
    end

    // A redirect squashes whatever is on the output in the same cycle.
    assign fetch_valid = sel_valid && !redirect;
    assign fetch_pc    = redirect ? '0 : sel_pc;
    assign fetch_inst  = redirect ? '0 : sel_inst;
    assign fetch_count = count_reg;

    assign accept       = fetch_valid && !stall && !redirect;
    assign skid_capture = stall && inflight_reg && !skid_valid_reg && !redirect;

    // Next-state logic; a redirect always lands back in RUN.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN:  if (stall && fetch_valid && !redirect) state_next = ST_HOLD;
            ST_HOLD: if (!stall || redirect) state_next = ST_RUN;
            default: state_next = ST_BOOT;
        endcase
        if (redirect) begin
            state_next = ST_RUN;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    // PC and in-flight read tracking; a redirect discards the outstanding read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg          <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                inflight_pc_reg <= pc_reg;
            end
            if (redirect) begin
                pc_reg <= redirect_pc;
            end else if (issue) begin
                pc_reg <= pc_reg + PC_WIDTH'(PC_STEP);
            end
        end
    end

    // Skid entry: parks the returning read while stalled, drains on the first free cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_reg <= 1'b0;
            skid_pc_reg    <= '0;
            skid_inst_reg  <= '0;
        end else if (redirect) begin
            skid_valid_reg <= 1'b0;
        end else if (skid_capture) begin
            skid_valid_reg <= 1'b1;
            skid_pc_reg    <= inflight_pc_reg;
            skid_inst_reg  <= imem_rdata;
        end else if (!stall) begin
            skid_valid_reg <= 1'b0;
        end
    end

    // Saturating count of instructions handed downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (accept && (count_reg != 32'hFFFF_FFFF)) begin
            count_reg <= count_reg + 32'd1;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a scoreboard queue holds the
// {pc, inst} pairs expected downstream; a monitor pops one per accepted cycle.
module tb_if_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [21:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [21:0] imem_rdata = '0;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [21:0] fetch_inst;
    logic [31:0] fetch_count;

    logic        rst2, stall2, redirect2;
    logic [31:0] redirect_pc2;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic [21:0] imem_rdata2 = '0;
    logic        fetch_valid2;
    logic [31:0] fetch_pc2;
    logic [21:0] fetch_inst2;
    logic [31:0] fetch_count2;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   accepted_exp = 0;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .fetch_inst(fetch_inst), .fetch_count(fetch_count)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFE)) dut_wrap (
        .clk(clk), .rst(rst2), .stall(stall2), .redirect(redirect2),
        .redirect_pc(redirect_pc2), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .fetch_valid(fetch_valid2), .fetch_pc(fetch_pc2),
        .fetch_inst(fetch_inst2), .fetch_count(fetch_count2)
    );

    function automatic logic [21:0] inst_of(input logic [31:0] a);
        return (a[21:0] * 22'd13) ^ 22'h15A3C ^ {12'd0, a[31:22]};
    endfunction

    // Synchronous instruction memories, one-cycle read latency.
    always @(posedge clk) begin
        if (imem_req)  imem_rdata  <= inst_of(imem_addr);
        if (imem_req2) imem_rdata2 <= inst_of(imem_addr2);
    end

    task automatic push_pc(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = inst_of(pc);
        sb_q.push_back(e);
        accepted_exp++;
    endtask

    // Scoreboard consumer: every accepted output must match the queue head.
    task automatic scoreboard_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && fetch_valid && !stall && !redirect) begin
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected: got pc=%h inst=%h, required none", fetch_pc, fetch_inst);
                end else begin
                    e = sb_q.pop_front();
                    if (fetch_pc !== e.pc || fetch_inst !== e.inst) begin
                        miscompares++;
                        $display("FAIL sb_item: got pc=%h inst=%h, required pc=%h inst=%h",
                                 fetch_pc, fetch_inst, e.pc, e.inst);
                    end else begin
                        $display("accept pc=%h inst=%h", fetch_pc, fetch_inst);
                    end
                end
            end
        end
    endtask

    // Let the queue empty, then stall so the stream stops on a known item.
    task automatic drain_and_stall(input string name);
        int n;
        for (n = 0; n < 200; n++) begin
            @(posedge clk);
            if (sb_q.size() == 0) break;
        end
        vectors++;
        if (n >= 200) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d items left, required 0", name, sb_q.size());
            sb_q.delete();
        end
        #1 stall = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (fetch_valid !== 1'b0 || fetch_pc !== 32'd0 || fetch_inst !== 22'd0) begin
            miscompares++;
            $display("FAIL reset_out: got v=%b pc=%h inst=%h, required 0/0/0", fetch_valid, fetch_pc, fetch_inst);
        end
        vectors++;
        if (imem_req !== 1'b0 || imem_addr !== 32'd0 || fetch_count !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_req: got req=%b addr=%h cnt=%0d, required 0/0/0", imem_req, imem_addr, fetch_count);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 5; i++) push_pc(i);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL boot_req: got %b, required 0", imem_req);
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            miscompares++;
            $display("FAIL first_req: got req=%b addr=%h, required 1/0", imem_req, imem_addr);
        end
        drain_and_stall("stream");
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (fetch_valid !== 1'b1 || fetch_pc !== 32'd5 || fetch_inst !== inst_of(32'd5) || imem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold: got v=%b pc=%h inst=%h req=%b, required 1/5/%h/0",
                         fetch_valid, fetch_pc, fetch_inst, imem_req, inst_of(32'd5));
            end
            if (i == 0) begin
                vectors++;
                if (fetch_count !== 32'd5) begin
                    miscompares++;
                    $display("FAIL stall_count: got %0d, required 5", fetch_count);
                end
            end
            @(posedge clk);
        end
        for (int i = 5; i < 8; i++) push_pc(i);
        #1 stall = 1'b0;
        drain_and_stall("stall");
        @(negedge clk);
        vectors++;
        if (fetch_count !== accepted_exp) begin
            miscompares++;
            $display("FAIL stall_release_count: got %0d, required %0d", fetch_count, accepted_exp);
        end
    endtask

    task automatic test_redirect();
        push_pc(32'd8);
        @(posedge clk); #1 stall = 1'b0;
        @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        vectors++;
        if (fetch_valid !== 1'b0 || imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_same: got v=%b req=%b, required 0/0", fetch_valid, imem_req);
        end
        @(posedge clk); #1 redirect = 1'b0;
        for (int i = 0; i < 3; i++) push_pc(32'h100 + i);
        @(negedge clk);
        vectors++;
        if (fetch_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            miscompares++;
            $display("FAIL redir_next: got v=%b req=%b addr=%h, required 0/1/100", fetch_valid, imem_req, imem_addr);
        end
        drain_and_stall("redirect");
        @(negedge clk);
        vectors++;
        if (fetch_count !== accepted_exp) begin
            miscompares++;
            $display("FAIL redir_count: got %0d, required %0d", fetch_count, accepted_exp);
        end
    endtask

    task automatic test_redirect_stall_skid();
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (fetch_valid !== 1'b1 || fetch_pc !== 32'h103) begin
            miscompares++;
            $display("FAIL skid_full: got v=%b pc=%h, required 1/103", fetch_valid, fetch_pc);
        end
        @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        vectors++;
        if (fetch_valid !== 1'b0 || imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL rs_same: got v=%b req=%b, required 0/0", fetch_valid, imem_req);
        end
        @(posedge clk); #1 redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (fetch_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h200) begin
                miscompares++;
                $display("FAIL rs_flushed: got v=%b req=%b addr=%h, required 0/0/200", fetch_valid, imem_req, imem_addr);
            end
            @(posedge clk);
        end
        for (int i = 0; i < 4; i++) push_pc(32'h200 + i);
        #1 stall = 1'b0;
        drain_and_stall("redir_stall");
        @(negedge clk);
        vectors++;
        if (fetch_count !== accepted_exp) begin
            miscompares++;
            $display("FAIL rs_count: got %0d, required %0d", fetch_count, accepted_exp);
        end
    endtask

    task automatic test_reset_mid_stall();
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (fetch_valid !== 1'b1 || fetch_pc !== 32'h204) begin
            miscompares++;
            $display("FAIL rst_skid_full: got v=%b pc=%h, required 1/204", fetch_valid, fetch_pc);
        end
        @(posedge clk); #1 rst = 1'b1;
        #1;
        vectors++;
        if (fetch_valid !== 1'b0 || fetch_pc !== 32'd0 || fetch_inst !== 22'd0 ||
            imem_req !== 1'b0 || imem_addr !== 32'd0 || fetch_count !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_async: got v=%b pc=%h inst=%h req=%b addr=%h cnt=%0d, required all 0",
                     fetch_valid, fetch_pc, fetch_inst, imem_req, imem_addr, fetch_count);
        end
        accepted_exp = 0;
        for (int i = 0; i < 4; i++) push_pc(i);
        @(posedge clk); #1 rst = 1'b0; stall = 1'b0;
        @(negedge clk);
        vectors++;
        if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_reboot: got req=%b v=%b, required 0/0", imem_req, fetch_valid);
        end
        drain_and_stall("rst_restart");
        @(negedge clk);
        vectors++;
        if (fetch_count !== accepted_exp) begin
            miscompares++;
            $display("FAIL rst_count: got %0d, required %0d", fetch_count, accepted_exp);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] wrap_q[$];
        int n;
        wrap_q.push_back(32'hFFFF_FFFE);
        wrap_q.push_back(32'hFFFF_FFFF);
        wrap_q.push_back(32'h0000_0000);
        wrap_q.push_back(32'h0000_0001);
        @(posedge clk); #1 rst2 = 1'b0; stall2 = 1'b0;
        for (n = 0; n < 20 && wrap_q.size() != 0; n++) begin
            @(negedge clk);
            if (fetch_valid2 && !stall2) begin
                logic [31:0] want;
                want = wrap_q.pop_front();
                vectors++;
                if (fetch_pc2 !== want || fetch_inst2 !== inst_of(want)) begin
                    miscompares++;
                    $display("FAIL wrap_pc: got pc=%h inst=%h, required pc=%h inst=%h",
                             fetch_pc2, fetch_inst2, want, inst_of(want));
                end else begin
                    $display("wrap accept pc=%h", fetch_pc2);
                end
            end
        end
        @(posedge clk); #1 stall2 = 1'b1;
        vectors++;
        if (wrap_q.size() != 0) begin
            miscompares++;
            $display("FAIL wrap_timeout: got %0d left, required 0", wrap_q.size());
        end
    endtask

    initial begin
        rst2 = 1'b1; stall2 = 1'b1; redirect2 = 1'b0; redirect_pc2 = '0;
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stall_skid();
        test_reset_mid_stall();
        test_wrap();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
